// File: rtl/wb_bypass_history.sv
// wb_bypass_history: write-back forwarding to NUM_RD read ports from the current write and a DEPTH-entry history.
// Optional WB_BYPASS_STATS_EN adds per-port saturating hit counters on fwd_cnt.
module wb_bypass_history #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     hist_inv,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0] rf_rdata,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
`ifdef WB_BYPASS_STATS_EN
    output logic [NUM_RD*16-1:0]     fwd_cnt,
`endif
    output logic [NUM_RD-1:0]        fwd_hit
);
    logic [DEPTH-1:0]  h_v;
    logic [ADDR_W-1:0] h_a [DEPTH];
    logic [DATA_W-1:0] h_d [DEPTH];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] hd;
    logic              hh, same;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_v <= '0;
        end else begin
            h_v[0] <= wb_we && wb_addr != '0;
            for (int k = 1; k < DEPTH; k++) h_v[k] <= h_v[k-1] && !hist_inv;
        end
    end

    // Address/data carry no reset: they are only meaningful under h_v.
    always_ff @(posedge clk) begin
        h_a[0] <= wb_addr;
        h_d[0] <= wb_data;
        for (int k = 1; k < DEPTH; k++) begin
            h_a[k] <= h_a[k-1];
            h_d[k] <= h_d[k-1];
        end
    end

    always_comb begin
        rd_data = rf_rdata;
        fwd_hit = '0;
        a       = '0;
        hd      = '0;
        hh      = 1'b0;
        same    = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            a  = rd_addr[i*ADDR_W +: ADDR_W];
            hh = 1'b0;
            hd = '0;
            // Scan oldest to youngest so the youngest match overrides.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (h_v[k] && h_a[k] == a) begin
                    hh = 1'b1;
                    hd = h_d[k];
                end
            end
            same = reset_n && wb_we && wb_addr == a;
            if (a != '0 && (same || hh)) begin
                fwd_hit[i] = 1'b1;
                rd_data[i*DATA_W +: DATA_W] = same ? wb_data : hd;
            end
        end
    end

`ifdef WB_BYPASS_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++)
                if (fwd_hit[i] && fwd_cnt[i*16 +: 16] != 16'hFFFF)
                    fwd_cnt[i*16 +: 16] <= fwd_cnt[i*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule
